// File: rtl/fetch_stage_pkg.sv
// Shared types, widths and helpers for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int WORD_W = 32;
    localparam int IMM_W  = 16;
    localparam int ADDR_W = 26;

    typedef logic [WORD_W-1:0] word_t;

    // Next-PC source select driven by the hazard unit.
    typedef enum logic [1:0] {
        SEL_NPC    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_JR     = 2'd3
    } pc_mux_input_selection;

    // Sign-extended, word-scaled branch displacement.
    function automatic word_t branch_offset(input logic [IMM_W-1:0] imm);
        return {{14{imm[IMM_W-1]}}, imm, 2'b00};
    endfunction

    // Pseudo-direct jump target: upper nibble of npc, 26-bit field, word aligned.
    function automatic word_t jump_target(input word_t npc, input logic [ADDR_W-1:0] jaddr);
        return {npc[31:28], jaddr, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of hazard-unit, EX_MEM operand, imem and IF_ID signals seen by fetch.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic                  enable_pc;
    pc_mux_input_selection PCSrc;
    logic                  halt;
    logic                  ihit;
    word_t                 imemload;
    word_t                 npc_EX_MEM;
    logic [IMM_W-1:0]      imm16_EX_MEM;
    logic [ADDR_W-1:0]     jaddr_EX_MEM;
    word_t                 rs_data_EX_MEM;
    logic                  imemREN;
    word_t                 imemaddr;
    word_t                 instr_IF;
    word_t                 npc_IF;
    logic                  fetch_valid;
    logic                  redirect_pend;

    modport fetch_stage (
        input  enable_pc, PCSrc, halt, ihit, imemload,
               npc_EX_MEM, imm16_EX_MEM, jaddr_EX_MEM, rs_data_EX_MEM,
        output imemREN, imemaddr, instr_IF, npc_IF, fetch_valid, redirect_pend
    );

    modport tb (
        output enable_pc, PCSrc, halt, ihit, imemload,
               npc_EX_MEM, imm16_EX_MEM, jaddr_EX_MEM, rs_data_EX_MEM,
        input  imemREN, imemaddr, instr_IF, npc_IF, fetch_valid, redirect_pend
    );

endinterface

// File: rtl/fetch_stage_pc_target_calc.sv
// Combinational next-PC candidate generator: sequential PC and the selected target.
module fetch_stage_pc_target_calc
    import fetch_stage_pkg::*;
#(
    parameter word_t PC_STEP = 32'd4
) (
    input  pc_mux_input_selection sel,
    input  word_t                 pc,
    input  word_t                 npc_ex,
    input  logic [IMM_W-1:0]      imm16,
    input  logic [ADDR_W-1:0]     jaddr,
    input  word_t                 rs_data,
    output word_t                 npc_seq,
    output word_t                 target
);

    assign npc_seq = pc + PC_STEP;

    // Select the target for the requested source; JR is passed through unaligned.
    always_comb begin
        target = npc_seq;
        case (sel)
            SEL_NPC:    target = npc_seq;
            SEL_BRANCH: target = npc_ex + branch_offset(imm16);
            SEL_JUMP:   target = jump_target(npc_ex, jaddr);
            SEL_JR:     target = rs_data;
            default:    target = npc_seq;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// PC register and next-PC selection with buffered redirects and sticky halt.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000,
    parameter word_t PC_STEP = 32'd4
) (
    input logic                CLK,
    input logic                nRST,
    fetch_stage_if.fetch_stage fif
);

    word_t pc_q,       pc_d;
    word_t redir_q,    redir_d;
    logic  redir_v_q,  redir_v_d;
    logic  halted_q,   halted_d;
    word_t npc_seq_s;
    word_t target_s;
    logic  redirect_s;

    fetch_stage_pc_target_calc #(.PC_STEP(PC_STEP)) u_target (
        .sel     (fif.PCSrc),
        .pc      (pc_q),
        .npc_ex  (fif.npc_EX_MEM),
        .imm16   (fif.imm16_EX_MEM),
        .jaddr   (fif.jaddr_EX_MEM),
        .rs_data (fif.rs_data_EX_MEM),
        .npc_seq (npc_seq_s),
        .target  (target_s)
    );

    assign redirect_s = (fif.PCSrc != SEL_NPC);

    // Next-state: live redirect beats buffered redirect beats sequential fetch.
    always_comb begin
        pc_d      = pc_q;
        redir_d   = redir_q;
        redir_v_d = redir_v_q;
        halted_d  = halted_q | fif.halt;
        if (halted_q) begin
            redir_v_d = 1'b0;
        end else if (fif.enable_pc) begin
            if (redirect_s) begin
                pc_d      = target_s;
                redir_v_d = 1'b0;
            end else if (redir_v_q) begin
                pc_d      = redir_q;
                redir_v_d = 1'b0;
            end else begin
                pc_d      = npc_seq_s;
            end
        end else begin
            if (redirect_s) begin
                redir_d   = target_s;
                redir_v_d = 1'b1;
            end else begin
                redir_d   = redir_q;
            end
        end
    end

    // Fetch state registers with asynchronous reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q      <= PC_INIT;
            redir_q   <= 32'h0000_0000;
            redir_v_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            redir_q   <= redir_d;
            redir_v_q <= redir_v_d;
            halted_q  <= halted_d;
        end
    end

    assign fif.imemREN       = ~halted_q;
    assign fif.imemaddr      = pc_q;
    assign fif.npc_IF        = npc_seq_s;
    assign fif.instr_IF      = fif.imemload;
    assign fif.fetch_valid   = fif.ihit & ~halted_q;
    assign fif.redirect_pend = redir_v_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam word_t IMEM_WORD = 32'hDEAD_BEEF;

    typedef struct {
        int    due;
        int    idx;
        word_t pc;
        logic  pend;
        logic  halted;
    } exp_t;

    logic CLK = 1'b0;
    logic nRST;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_pushed = 0;
    exp_t sb_q[$];
    exp_t cur;

    fetch_stage_if fif ();

    fetch_stage #(.PC_INIT(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .fif  (fif.fetch_stage)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_val(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Monitor: compare every expectation that has come due against the DUT.
    always @(negedge CLK) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            cur = sb_q.pop_front();
            check_val("imemaddr",      cur.idx, fif.imemaddr, cur.pc);
            check_val("npc_IF",        cur.idx, fif.npc_IF, cur.pc + 32'd4);
            check_val("imemREN",       cur.idx, {31'd0, fif.imemREN}, {31'd0, ~cur.halted});
            check_val("fetch_valid",   cur.idx, {31'd0, fif.fetch_valid}, {31'd0, ~cur.halted});
            check_val("redirect_pend", cur.idx, {31'd0, fif.redirect_pend}, {31'd0, cur.pend});
            check_val("instr_IF",      cur.idx, fif.instr_IF, IMEM_WORD);
        end
    end

    task automatic idle();
        fif.enable_pc      = 1'b0;
        fif.PCSrc          = SEL_NPC;
        fif.halt           = 1'b0;
        fif.npc_EX_MEM     = 32'h0000_0000;
        fif.imm16_EX_MEM   = 16'h0000;
        fif.jaddr_EX_MEM   = 26'h000_0000;
        fif.rs_data_EX_MEM = 32'h0000_0000;
    endtask

    // Drive one cycle of stimulus and queue the state expected after the next edge.
    task automatic step(input logic en, input pc_mux_input_selection src, input word_t npc_ex,
                        input logic [15:0] imm, input logic [25:0] ja, input word_t rs,
                        input logic hlt, input word_t exp_pc, input logic exp_pend, input logic exp_halt);
        exp_t e;
        @(posedge CLK);
        #1;
        fif.enable_pc      = en;
        fif.PCSrc          = src;
        fif.npc_EX_MEM     = npc_ex;
        fif.imm16_EX_MEM   = imm;
        fif.jaddr_EX_MEM   = ja;
        fif.rs_data_EX_MEM = rs;
        fif.halt           = hlt;
        e.due    = cyc + 1;
        e.idx    = n_pushed;
        e.pc     = exp_pc;
        e.pend   = exp_pend;
        e.halted = exp_halt;
        n_pushed++;
        sb_q.push_back(e);
    endtask

    // Park inputs and wait (bounded) for the monitor to consume all expectations.
    task automatic drain();
        @(posedge CLK);
        #1;
        idle();
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge CLK);
        #1;
        check_val("drain", 0, sb_q.size(), 32'd0);
    endtask

    initial begin
        nRST          = 1'b0;
        fif.ihit      = 1'b1;
        fif.imemload  = IMEM_WORD;
        idle();
        #2;
        check_val("rst_imemaddr", 0, fif.imemaddr, 32'h0000_0000);
        check_val("rst_imemREN",  0, {31'd0, fif.imemREN}, 32'd1);
        check_val("rst_fvalid",   0, {31'd0, fif.fetch_valid}, 32'd1);
        check_val("rst_pend",     0, {31'd0, fif.redirect_pend}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // Sequential fetch
        step(1'b1, SEL_NPC, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0000_0004, 1'b0, 1'b0);
        step(1'b1, SEL_NPC, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
        step(1'b1, SEL_NPC, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0000_000C, 1'b0, 1'b0);
        step(1'b1, SEL_NPC, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0000_0010, 1'b0, 1'b0);
        // JR to 0x40, then backward and forward branches
        step(1'b1, SEL_JR,     32'h0,        16'h0,    26'h0, 32'h0000_0040, 1'b0, 32'h0000_0040, 1'b0, 1'b0);
        step(1'b1, SEL_BRANCH, 32'h0000_0044, 16'hFFFE, 26'h0, 32'h0,        1'b0, 32'h0000_003C, 1'b0, 1'b0);
        step(1'b1, SEL_BRANCH, 32'h0000_0044, 16'h0003, 26'h0, 32'h0,        1'b0, 32'h0000_0050, 1'b0, 1'b0);
        // Jump requested during stall is buffered, then applied
        step(1'b0, SEL_JUMP, 32'h1000_0010, 16'h0, 26'h100, 32'h0, 1'b0, 32'h0000_0050, 1'b1, 1'b0);
        step(1'b1, SEL_NPC,  32'h0,         16'h0, 26'h0,   32'h0, 1'b0, 32'h1000_0400, 1'b0, 1'b0);
        // Live redirect beats pending one; pending one is dropped
        step(1'b0, SEL_JR,     32'h0,         16'h0, 26'h0, 32'h0000_0200, 1'b0, 32'h1000_0400, 1'b1, 1'b0);
        step(1'b1, SEL_BRANCH, 32'h0000_0080, 16'h0, 26'h0, 32'h0,         1'b0, 32'h0000_0080, 1'b0, 1'b0);
        step(1'b1, SEL_NPC,    32'h0,         16'h0, 26'h0, 32'h0,         1'b0, 32'h0000_0084, 1'b0, 1'b0);
        // Latest buffered redirect overwrites an older one
        step(1'b0, SEL_JR,  32'h0, 16'h0, 26'h0, 32'h0000_0300, 1'b0, 32'h0000_0084, 1'b1, 1'b0);
        step(1'b0, SEL_JR,  32'h0, 16'h0, 26'h0, 32'h0000_0200, 1'b0, 32'h0000_0084, 1'b1, 1'b0);
        step(1'b0, SEL_NPC, 32'h0, 16'h0, 26'h0, 32'h0,         1'b0, 32'h0000_0084, 1'b1, 1'b0);
        step(1'b1, SEL_NPC, 32'h0, 16'h0, 26'h0, 32'h0,         1'b0, 32'h0000_0200, 1'b0, 1'b0);
        // Halt at 0x24: frozen, no fetch, no redirect capture
        step(1'b1, SEL_JR,  32'h0, 16'h0, 26'h0, 32'h0000_0024, 1'b0, 32'h0000_0024, 1'b0, 1'b0);
        step(1'b0, SEL_NPC, 32'h0, 16'h0, 26'h0, 32'h0,         1'b1, 32'h0000_0024, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            step(1'b1, SEL_NPC, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 32'h0000_0024, 1'b0, 1'b1);
        step(1'b0, SEL_JR,  32'h0, 16'h0, 26'h0, 32'h0000_0500, 1'b0, 32'h0000_0024, 1'b0, 1'b1);
        step(1'b1, SEL_NPC, 32'h0, 16'h0, 26'h0, 32'h0,         1'b0, 32'h0000_0024, 1'b0, 1'b1);
        drain();
        nRST = 1'b0;
        #1;
        check_val("halt_rst_pc",  0, fif.imemaddr, 32'h0000_0000);
        check_val("halt_rst_ren", 0, {31'd0, fif.imemREN}, 32'd1);
        @(negedge CLK);
        nRST = 1'b1;

        // Wrap from the top of the address space
        step(1'b1, SEL_JR,  32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0);
        step(1'b1, SEL_NPC, 32'h0, 16'h0, 26'h0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0);
        // Async reset clears a pending redirect immediately
        step(1'b0, SEL_BRANCH, 32'h0000_0100, 16'h0001, 26'h0, 32'h0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        drain();
        nRST = 1'b0;
        #1;
        check_val("async_rst_pend", 0, {31'd0, fif.redirect_pend}, 32'd0);
        check_val("async_rst_pc",   0, fif.imemaddr, 32'h0000_0000);
        @(negedge CLK);
        nRST = 1'b1;

        // Halt and redirect on the same edge: redirect lands, then frozen
        step(1'b1, SEL_JUMP, 32'h2000_0000, 16'h0, 26'h10, 32'h0, 1'b1, 32'h2000_0040, 1'b0, 1'b1);
        step(1'b1, SEL_NPC,  32'h0,         16'h0, 26'h0,  32'h0, 1'b0, 32'h2000_0040, 1'b0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
